// File: rtl/alu_arbiter.sv
// alu_arbiter -- two-requester round-robin front end for one shared,
// multi-cycle ALU.  One operation is in flight at a time.
//
// Flow: IDLE grants one requester and latches its packet, ISSUE drives the
// ALU pins for exactly one cycle (ALU_CE=1), WAIT counts down the ALU
// latency and samples ALU_RES/ALU_FLAGS, RESP holds the response until it
// is consumed.
//
// Handshake semantics (both request and response sides):
//   a transfer happens on a rising CLK edge where VALID && READY are both 1.
//   VALID may not depend on READY; once raised, VALID and its payload stay
//   stable until the transfer.  REQx_READY is combinational and only ever
//   high in IDLE (and never while RST_N is low).
//
// Ports
//   CLK, RST_N                 clock, async active-low reset
//   REQ0_VALID/PKT/READY       requester 0 (packet {MODE,CIN,INP_VALID,CMD,OPA,OPB})
//   REQ1_VALID/PKT/READY       requester 1
//   ALU_CE .. ALU_OPB          drive of the shared ALU (all 0 outside ISSUE)
//   ALU_RES, ALU_FLAGS         ALU result and flags {ERR,OFLOW,COUT,G,L,E,NEG,ZERO}
//   RSP_VALID/READY            response handshake
//   RSP_ID, RSP_RES, RSP_FLAGS response owner and captured ALU outputs
//   BUSY                       FSM not in IDLE
//   DBG_STATE                  current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int PKT_W = 2*WIDTH+8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               REQ0_VALID,
  input  logic [PKT_W-1:0]   REQ0_PKT,
  output logic               REQ0_READY,
  input  logic               REQ1_VALID,
  input  logic [PKT_W-1:0]   REQ1_PKT,
  output logic               REQ1_READY,
  output logic               ALU_CE,
  output logic               ALU_MODE,
  output logic               ALU_CIN,
  output logic [1:0]         ALU_INP_VALID,
  output logic [3:0]         ALU_CMD,
  output logic [WIDTH-1:0]   ALU_OPA,
  output logic [WIDTH-1:0]   ALU_OPB,
  input  logic [2*WIDTH-1:0] ALU_RES,
  input  logic [7:0]         ALU_FLAGS,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic               RSP_ID,
  output logic [2*WIDTH-1:0] RSP_RES,
  output logic [7:0]         RSP_FLAGS,
  output logic               BUSY,
  output logic [1:0]         DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [PKT_W-1:0]     pkt_q;
  logic                 id_q;
  logic                 prio_q;     // requester that wins a tie (0 or 1)
  logic [1:0]           cnt_q;
  logic [2*WIDTH-1:0]   res_q;
  logic [7:0]           flags_q;

  // Latched packet fields, MSB first.
  logic                 pkt_mode;
  logic                 pkt_cin;
  logic [1:0]           pkt_iv;
  logic [3:0]           pkt_cmd;
  logic [WIDTH-1:0]     pkt_opa;
  logic [WIDTH-1:0]     pkt_opb;
  logic                 is_mul;
  logic [1:0]           lat_m1;

  assign pkt_mode = pkt_q[PKT_W-1];
  assign pkt_cin  = pkt_q[PKT_W-2];
  assign pkt_iv   = pkt_q[PKT_W-3 -: 2];
  assign pkt_cmd  = pkt_q[PKT_W-5 -: 4];
  assign pkt_opa  = pkt_q[2*WIDTH-1 -: WIDTH];
  assign pkt_opb  = pkt_q[WIDTH-1:0];

  // Multiply commands take one extra ALU cycle; the counter holds latency-1.
  assign is_mul = pkt_mode && ((pkt_cmd == 4'b1001) || (pkt_cmd == 4'b1010));
  assign lat_m1 = is_mul ? 2'd2 : 2'd1;

  // Round-robin: a lone requester always wins, a tie goes to prio_q.
  logic win0, win1;
  assign win0 = REQ0_VALID && (!REQ1_VALID || !prio_q);
  assign win1 = REQ1_VALID && (!REQ0_VALID ||  prio_q);

  // RST_N gating keeps READY low while reset is held even though the
  // state register already sits in IDLE.
  assign REQ0_READY = RST_N && (state_q == S_IDLE) && win0;
  assign REQ1_READY = RST_N && (state_q == S_IDLE) && win1;

  assign RSP_VALID = (state_q == S_RESP);
  assign RSP_ID    = id_q;
  assign RSP_RES   = res_q;
  assign RSP_FLAGS = flags_q;
  assign BUSY      = (state_q != S_IDLE);
  assign DBG_STATE = state_q;

  always_comb begin
    state_d       = state_q;
    ALU_CE        = 1'b0;
    ALU_MODE      = 1'b0;
    ALU_CIN       = 1'b0;
    ALU_INP_VALID = 2'b00;
    ALU_CMD       = 4'b0000;
    ALU_OPA       = '0;
    ALU_OPB       = '0;
    case (state_q)
      S_IDLE: begin
        if (REQ0_READY || REQ1_READY) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        ALU_CE        = 1'b1;
        ALU_MODE      = pkt_mode;
        ALU_CIN       = pkt_cin;
        ALU_INP_VALID = pkt_iv;
        ALU_CMD       = pkt_cmd;
        ALU_OPA       = pkt_opa;
        ALU_OPB       = pkt_opb;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) state_d = S_RESP;
      end
      S_RESP: begin
        if (RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      pkt_q   <= '0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= 2'd0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (REQ0_READY || REQ1_READY) begin
            pkt_q  <= REQ1_READY ? REQ1_PKT : REQ0_PKT;
            id_q   <= REQ1_READY;
            // The requester just served loses the next tie.
            prio_q <= REQ0_READY;
          end
        end
        S_ISSUE: cnt_q <= lat_m1;
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            res_q   <= ALU_RES;
            flags_q <= ALU_FLAGS;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU that presents its result only in
// the exact capture cycle, a table of single-requester operations, and
// hand-written contention, backpressure and reset-in-WAIT sequences.
module tb_alu_arbiter;

  localparam int W  = 8;
  localparam int PW = 2*W+8;
  localparam int EW = 25;   // expected response: {id, flags[7:0], res[15:0]}

  logic          CLK, RST_N;
  logic          REQ0_VALID, REQ1_VALID, REQ0_READY, REQ1_READY;
  logic [PW-1:0] REQ0_PKT, REQ1_PKT;
  logic          ALU_CE, ALU_MODE, ALU_CIN;
  logic [1:0]    ALU_INP_VALID;
  logic [3:0]    ALU_CMD;
  logic [W-1:0]  ALU_OPA, ALU_OPB;
  logic [2*W-1:0] ALU_RES;
  logic [7:0]    ALU_FLAGS;
  logic          RSP_VALID, RSP_READY, RSP_ID, BUSY;
  logic [2*W-1:0] RSP_RES;
  logic [7:0]    RSP_FLAGS;
  logic [1:0]    DBG_STATE;

  alu_arbiter #(.WIDTH(W), .PKT_W(PW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(REQ0_VALID), .REQ0_PKT(REQ0_PKT), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_PKT(REQ1_PKT), .REQ1_READY(REQ1_READY),
    .ALU_CE(ALU_CE), .ALU_MODE(ALU_MODE), .ALU_CIN(ALU_CIN),
    .ALU_INP_VALID(ALU_INP_VALID), .ALU_CMD(ALU_CMD),
    .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB),
    .ALU_RES(ALU_RES), .ALU_FLAGS(ALU_FLAGS),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS), .BUSY(BUSY),
    .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_rsp();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check("rsp_unexpected", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("rsp_id",    {31'd0, RSP_ID}, {31'd0, e[24]});
      check("rsp_flags", {24'd0, RSP_FLAGS}, {24'd0, e[23:16]});
      check("rsp_res",   {16'd0, RSP_RES}, {16'd0, e[15:0]});
    end
  endtask

  task automatic wait_rsp(input string name);
    bit seen = 0;
    for (int k = 0; k < 15 && !seen; k++) begin
      @(negedge CLK); #1;
      if (RSP_VALID) seen = 1;
    end
    if (seen) check_rsp();
    else      check(name, 32'd0, 32'd1);
  endtask

  function automatic logic [PW-1:0] mk_pkt(input logic mode, input logic cin,
      input logic [1:0] iv, input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
    return {mode, cin, iv, cmd, a, b};
  endfunction

  // ---------------- behavioural ALU ----------------
  // Returns {flags, res}.  ERR on INP_VALID=00, ZERO on a zero result.
  function automatic logic [23:0] alu_model(input logic mode, input logic [1:0] iv,
      input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    if (iv == 2'b00) return {8'h80, 16'h0000};
    r = 16'h0000;
    if (mode) begin
      case (cmd)
        4'd0:  r = {8'd0, a} + {8'd0, b};
        4'd1:  r = {8'd0, a} - {8'd0, b};
        4'd9:  r = ({8'd0, a} + 16'd1) * ({8'd0, b} + 16'd1);
        4'd10: r = ({8'd0, a} << 1) * {8'd0, b};
        default: r = 16'h0000;
      endcase
    end else begin
      case (cmd)
        4'd0:  r = {8'd0, a & b};
        4'd1:  r = {8'd0, a | b};
        default: r = 16'h0000;
      endcase
    end
    return {7'd0, (r == 16'h0000), r};
  endfunction

  // Result is valid only during cycle ISSUE+L; garbage every other cycle.
  logic [23:0] alu_pend;
  int          alu_cd = 0;
  always @(negedge CLK) begin
    if (!RST_N) begin
      alu_cd    = 0;
      ALU_RES   = 16'hDEAD;
      ALU_FLAGS = 8'h5A;
    end else begin
      if (alu_cd > 0) begin
        alu_cd--;
        if (alu_cd == 0) {ALU_FLAGS, ALU_RES} = alu_pend;
        else begin ALU_RES = 16'hDEAD; ALU_FLAGS = 8'h5A; end
      end else begin
        ALU_RES = 16'hDEAD; ALU_FLAGS = 8'h5A;
      end
      if (ALU_CE) begin
        alu_pend = alu_model(ALU_MODE, ALU_INP_VALID, ALU_CMD, ALU_OPA, ALU_OPB);
        alu_cd   = (ALU_MODE && (ALU_CMD == 4'd9 || ALU_CMD == 4'd10)) ? 3 : 2;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        sel;
    logic        mode;
    logic        cin;
    logic [1:0]  iv;
    logic [3:0]  cmd;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_res;
    logic [7:0]  exp_flags;
    int          exp_lat;   // request handshake -> first RSP_VALID, in cycles
  } vec_t;

  vec_t vecs[7];

  // ---------------- stimulus ----------------
  initial begin
    int g_cyc, hs_cyc, n_grant, n_rsp;
    bit hs_seen;
    vec_t v;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 2'b11, 4'h0, 8'h0F, 8'h01, 16'h0010, 8'h00, 4}; // ADD
    vecs[1] = '{1'b1, 1'b1, 1'b0, 2'b11, 4'h9, 8'h03, 8'h04, 16'h0014, 8'h00, 5}; // MUL 1001
    vecs[2] = '{1'b0, 1'b1, 1'b0, 2'b11, 4'h1, 8'h10, 8'h10, 16'h0000, 8'h01, 4}; // SUB -> zero
    vecs[3] = '{1'b1, 1'b0, 1'b1, 2'b11, 4'h0, 8'hF0, 8'h3C, 16'h0030, 8'h00, 4}; // AND, CIN=1
    vecs[4] = '{1'b0, 1'b1, 1'b0, 2'b11, 4'hA, 8'h02, 8'h03, 16'h000C, 8'h00, 5}; // MUL 1010
    vecs[5] = '{1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 8'h55, 8'h66, 16'h0000, 8'h80, 4}; // ERR passthrough
    vecs[6] = '{1'b0, 1'b0, 1'b0, 2'b11, 4'h9, 8'h01, 8'h02, 16'h0000, 8'h01, 4}; // CMD 1001, MODE=0: not a multiply

    // ---- reset, both requesters already valid ----
    RST_N = 1'b0; RSP_READY = 1'b1;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    REQ0_PKT = mk_pkt(1'b1, 1'b0, 2'b11, 4'h0, 8'h01, 8'h02);  // 1+2 = 3
    REQ1_PKT = mk_pkt(1'b1, 1'b0, 2'b11, 4'h0, 8'h05, 8'h05);  // 5+5 = 0A
    repeat (3) @(negedge CLK);
    #1;
    check("reset_ready0",    {31'd0, REQ0_READY}, 32'd0);
    check("reset_ready1",    {31'd0, REQ1_READY}, 32'd0);
    check("reset_busy",      {31'd0, BUSY}, 32'd0);
    check("reset_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    check("reset_alu_ce",    {31'd0, ALU_CE}, 32'd0);
    check("reset_rsp_res",   {16'd0, RSP_RES}, 32'd0);
    check("reset_state",     {30'd0, DBG_STATE}, 32'd0);

    // ---- contention: grants and responses alternate 0,1,0,1 ----
    @(negedge CLK);
    RST_N = 1'b1;
    n_grant = 0; n_rsp = 0; hs_seen = 0; g_cyc = 0; hs_cyc = 0;
    for (int c = 0; c < 80 && n_rsp < 4; c++) begin
      #1;
      if (c == 0) check("first_grant_after_reset", {31'd0, REQ0_READY}, 32'd1);
      check("ready_onehot", {31'd0, REQ0_READY & REQ1_READY}, 32'd0);
      if (REQ0_READY || REQ1_READY) begin
        check("grant_order", {31'd0, REQ1_READY}, n_grant % 2);
        if (hs_seen) check("grant_after_handshake", c - hs_cyc, 32'd1);
        exp_q.push_back(REQ1_READY ? {1'b1, 8'h00, 16'h000A} : {1'b0, 8'h00, 16'h0003});
        g_cyc = c;
        n_grant++;
      end
      if (RSP_VALID) begin
        check("contention_rsp_id", {31'd0, RSP_ID}, n_rsp % 2);
        check("contention_latency", c - g_cyc, 32'd4);
        check_rsp();
        n_rsp++;
        hs_seen = 1;
        hs_cyc  = c;
        if (n_rsp == 4) begin REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; end
      end
      if (n_rsp < 4) @(negedge CLK);
    end
    check("contention_done", n_rsp, 32'd4);

    // ---- table: one requester at a time, RSP_READY=1 ----
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      @(negedge CLK); #1;
      check("idle_before_vec", {31'd0, BUSY}, 32'd0);
      if (v.sel) begin REQ1_VALID = 1'b1; REQ1_PKT = mk_pkt(v.mode, v.cin, v.iv, v.cmd, v.a, v.b); end
      else       begin REQ0_VALID = 1'b1; REQ0_PKT = mk_pkt(v.mode, v.cin, v.iv, v.cmd, v.a, v.b); end
      #1;
      check("vec_ready_winner", {31'd0, v.sel ? REQ1_READY : REQ0_READY}, 32'd1);
      check("vec_ready_loser",  {31'd0, v.sel ? REQ0_READY : REQ1_READY}, 32'd0);
      exp_q.push_back({v.sel, v.exp_flags, v.exp_res});
      @(posedge CLK); #1;
      REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
      for (int k = 1; k <= v.exp_lat; k++) begin
        @(negedge CLK); #1;
        check("vec_alu_ce", {31'd0, ALU_CE}, (k == 1) ? 32'd1 : 32'd0);
        if (k == 1) begin
          check("vec_alu_mode", {31'd0, ALU_MODE}, {31'd0, v.mode});
          check("vec_alu_cin",  {31'd0, ALU_CIN}, {31'd0, v.cin});
          check("vec_alu_iv",   {30'd0, ALU_INP_VALID}, {30'd0, v.iv});
          check("vec_alu_cmd",  {28'd0, ALU_CMD}, {28'd0, v.cmd});
          check("vec_alu_opa",  {24'd0, ALU_OPA}, {24'd0, v.a});
          check("vec_alu_opb",  {24'd0, ALU_OPB}, {24'd0, v.b});
        end
        if (k == 2) begin
          check("vec_alu_opa_idle", {24'd0, ALU_OPA}, 32'd0);
          check("vec_alu_cmd_idle", {28'd0, ALU_CMD}, 32'd0);
        end
        check("vec_busy", {31'd0, BUSY}, 32'd1);
        check("vec_rsp_valid_timing", {31'd0, RSP_VALID}, (k == v.exp_lat) ? 32'd1 : 32'd0);
        if (k == v.exp_lat && RSP_VALID) check_rsp();
      end
    end

    // ---- backpressure: RSP_READY low for 5 response cycles ----
    @(negedge CLK); #1;
    REQ0_VALID = 1'b1;
    REQ0_PKT   = mk_pkt(1'b1, 1'b0, 2'b11, 4'h0, 8'h0F, 8'h01);
    exp_q.push_back({1'b0, 8'h00, 16'h0010});
    @(posedge CLK); #1;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b1;
    REQ1_PKT   = mk_pkt(1'b1, 1'b0, 2'b11, 4'h0, 8'h02, 8'h02);
    RSP_READY  = 1'b0;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); #1;
      check("bp_rsp_valid", {31'd0, RSP_VALID}, 32'd1);
      check("bp_rsp_id",    {31'd0, RSP_ID}, 32'd0);
      check("bp_rsp_res",   {16'd0, RSP_RES}, 32'h0010);
      check("bp_rsp_flags", {24'd0, RSP_FLAGS}, 32'd0);
      check("bp_ready1",    {31'd0, REQ1_READY}, 32'd0);
      check("bp_busy",      {31'd0, BUSY}, 32'd1);
    end
    @(negedge CLK); #1;
    RSP_READY = 1'b1;
    #1;
    check("bp_no_grant_in_handshake", {31'd0, REQ1_READY}, 32'd0);
    check("bp_rsp_valid_hs", {31'd0, RSP_VALID}, 32'd1);
    if (RSP_VALID) check_rsp();
    @(negedge CLK); #1;
    check("bp_grant_next_cycle", {31'd0, REQ1_READY}, 32'd1);
    exp_q.push_back({1'b1, 8'h00, 16'h0004});
    @(posedge CLK); #1;
    REQ1_VALID = 1'b0;
    wait_rsp("bp_second_rsp_timeout");

    // ---- reset during WAIT ----
    @(negedge CLK); #1;
    REQ0_VALID = 1'b1;
    REQ0_PKT   = mk_pkt(1'b1, 1'b0, 2'b11, 4'h9, 8'h03, 8'h04);
    @(posedge CLK); #1;
    REQ1_VALID = 1'b1;                       // both valid while busy
    @(negedge CLK);                          // ISSUE
    @(negedge CLK);                          // WAIT
    #1;
    check("rst_pre_busy", {31'd0, BUSY}, 32'd1);
    RST_N = 1'b0;
    #1;
    check("rst_ready0",    {31'd0, REQ0_READY}, 32'd0);
    check("rst_ready1",    {31'd0, REQ1_READY}, 32'd0);
    check("rst_alu_ce",    {31'd0, ALU_CE}, 32'd0);
    check("rst_alu_opa",   {24'd0, ALU_OPA}, 32'd0);
    check("rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    check("rst_rsp_id",    {31'd0, RSP_ID}, 32'd0);
    check("rst_rsp_res",   {16'd0, RSP_RES}, 32'd0);
    check("rst_rsp_flags", {24'd0, RSP_FLAGS}, 32'd0);
    check("rst_busy",      {31'd0, BUSY}, 32'd0);
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); #1;
      check("rst_no_stale_rsp", {31'd0, RSP_VALID}, 32'd0);
      check("rst_idle_after",   {31'd0, BUSY}, 32'd0);
    end
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    REQ0_PKT = mk_pkt(1'b1, 1'b0, 2'b11, 4'h0, 8'h01, 8'h02);
    REQ1_PKT = mk_pkt(1'b1, 1'b0, 2'b11, 4'h0, 8'h05, 8'h05);
    #1;
    check("rst_tie_req0_wins", {31'd0, REQ0_READY}, 32'd1);
    check("rst_tie_req1_loses", {31'd0, REQ1_READY}, 32'd0);
    exp_q.push_back({1'b0, 8'h00, 16'h0003});
    @(posedge CLK); #1;
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    wait_rsp("rst_rsp_timeout");

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
